// File: rtl/alt_xcvr_reset_sequencer.sv
// PLL / transceiver reset sequencer for one channel group.
// Orders reset release, waits for lock/ready, retries on timeout.
module alt_xcvr_reset_sequencer #(
    parameter int PULSE_CYCLES  = 64,
    parameter int SETTLE_CYCLES = 256,
    parameter int TIMEOUT_BITS  = 20,
    parameter int MAX_RETRIES   = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_reset,
    input  logic       pll_locked,
    input  logic       xcvr_ready,
    output logic       pll_reset,
    output logic       xcvr_reset,
    output logic       ready_out,
    output logic       fail,
    output logic [3:0] retry_count
);

    localparam int PW  = $clog2(PULSE_CYCLES);
    localparam int SW  = $clog2(SETTLE_CYCLES);
    localparam int CW0 = (TIMEOUT_BITS > PW) ? TIMEOUT_BITS : PW;
    localparam int CW  = (CW0 > SW) ? CW0 : SW;

    localparam logic [CW-1:0] PULSE_LAST  = CW'(PULSE_CYCLES - 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] TMO_LAST    = {CW{1'b1}} >> (CW - TIMEOUT_BITS);
    localparam logic [3:0]    MAX_RC      = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        ST_ASSERT,
        ST_WAIT_LOCK,
        ST_SETTLE,
        ST_WAIT_READY,
        ST_RUN,
        ST_FAIL
    } state_e;

    logic [2:0]    lock_sync_q;
    logic [2:0]    rdy_sync_q;
    logic          lock_s;
    logic          rdy_s;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    retry_q, retry_d;
    logic [3:0]    retry_inc;
    logic          restart;
    logic          timeout;
    logic          cnt_tmo;

    logic          pll_reset_q;
    logic          xcvr_reset_q;
    logic          ready_q;
    logic          fail_q;

    // Three-flop synchronisers for the asynchronous status inputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_sync_q <= 3'b000;
            rdy_sync_q  <= 3'b000;
        end else begin
            lock_sync_q <= {lock_sync_q[1:0], pll_locked};
            rdy_sync_q  <= {rdy_sync_q[1:0], xcvr_ready};
        end
    end

    assign lock_s    = lock_sync_q[2];
    assign rdy_s     = rdy_sync_q[2];
    assign cnt_tmo   = (cnt_q == TMO_LAST);
    assign retry_inc = (retry_q == 4'hF) ? retry_q : retry_q + 4'd1;

    // Next state: req_reset, then loss, then success, then timeout
    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        restart = 1'b0;
        timeout = 1'b0;
        if (req_reset) begin
            state_d = ST_ASSERT;
            retry_d = 4'd0;
            restart = 1'b1;
        end else begin
            unique case (state_q)
                ST_ASSERT: begin
                    if (cnt_q == PULSE_LAST) state_d = ST_WAIT_LOCK;
                end
                ST_WAIT_LOCK: begin
                    if (lock_s)       state_d = ST_SETTLE;
                    else if (cnt_tmo) timeout = 1'b1;
                end
                ST_SETTLE: begin
                    if (!lock_s)                  state_d = ST_ASSERT;
                    else if (cnt_q == SETTLE_LAST) state_d = ST_WAIT_READY;
                end
                ST_WAIT_READY: begin
                    if (!lock_s)      state_d = ST_ASSERT;
                    else if (rdy_s)   state_d = ST_RUN;
                    else if (cnt_tmo) timeout = 1'b1;
                end
                ST_RUN: begin
                    if (!lock_s || !rdy_s) state_d = ST_ASSERT;
                end
                ST_FAIL: begin
                    state_d = ST_FAIL;
                end
                default: begin
                    state_d = ST_ASSERT;
                end
            endcase
            if (timeout) begin
                retry_d = retry_inc;
                state_d = (retry_inc >= MAX_RC) ? ST_FAIL : ST_ASSERT;
            end
        end
        cnt_d = (restart || (state_d != state_q)) ? '0 : cnt_q + CW'(1);
    end

    // State, shared timer and retry counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_ASSERT;
            cnt_q   <= '0;
            retry_q <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            retry_q <= retry_d;
        end
    end

    // Output flops track the decode of the state being entered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pll_reset_q  <= 1'b1;
            xcvr_reset_q <= 1'b1;
            ready_q      <= 1'b0;
            fail_q       <= 1'b0;
        end else begin
            pll_reset_q  <= (state_d == ST_ASSERT) || (state_d == ST_FAIL);
            xcvr_reset_q <= (state_d == ST_ASSERT) || (state_d == ST_WAIT_LOCK) ||
                            (state_d == ST_SETTLE) || (state_d == ST_FAIL);
            ready_q      <= (state_d == ST_RUN);
            fail_q       <= (state_d == ST_FAIL);
        end
    end

    assign pll_reset   = pll_reset_q;
    assign xcvr_reset  = xcvr_reset_q;
    assign ready_out   = ready_q;
    assign fail        = fail_q;
    assign retry_count = retry_q;

endmodule

// File: tb/tb_alt_xcvr_reset_sequencer.sv
// Bench for alt_xcvr_reset_sequencer: directed vectors, corner
// sequences and a randomized run against a cycle-level model.
module tb_alt_xcvr_reset_sequencer;

    localparam int P   = 4;
    localparam int S   = 8;
    localparam int TB  = 6;
    localparam int MR  = 3;
    localparam int TMO = 1 << TB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req = 1'b0;
    logic       lk  = 1'b1;
    logic       rd  = 1'b0;
    logic       pll, xr, rdy_o, fl;
    logic [3:0] rc;
    logic [7:0] obs;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    alt_xcvr_reset_sequencer #(
        .PULSE_CYCLES (P),
        .SETTLE_CYCLES(S),
        .TIMEOUT_BITS (TB),
        .MAX_RETRIES  (MR)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_reset  (req),
        .pll_locked (lk),
        .xcvr_ready (rd),
        .pll_reset  (pll),
        .xcvr_reset (xr),
        .ready_out  (rdy_o),
        .fail       (fl),
        .retry_count(rc)
    );

    assign obs = {pll, xr, rdy_o, fl, rc};

    typedef struct {
        logic       rst;
        logic       req;
        logic       lk;
        logic       rd;
        int         n;
        logic [7:0] exp;
    } vec_t;

    vec_t vt[15];

    function automatic logic [7:0] pk(bit p, bit x, bit r, bit f, int c);
        return {p, x, r, f, 4'(c)};
    endfunction

    function automatic vec_t mk(bit r, bit q, bit l, bit d, int n,
                                logic [7:0] e);
        vec_t v;
        v.rst = r; v.req = q; v.lk = l; v.rd = d; v.n = n; v.exp = e;
        return v;
    endfunction

    task automatic check(input string nm, input logic [7:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got {pll,xr,rdy,fail,rc}=%b_%b_%b_%b_%0d want %b_%b_%b_%b_%0d",
                      nm, obs[7], obs[6], obs[5], obs[4], obs[3:0],
                      exp[7], exp[6], exp[5], exp[4], exp[3:0]);
    endtask

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    // Reference model: phase name, cycles spent in phase, retries,
    // and the status inputs delayed by the three-cycle synchroniser.
    localparam int M_ASSERT = 0, M_WL = 1, M_SET = 2,
                   M_WR = 3, M_RUN = 4, M_FAIL = 5;
    int m_ph, m_el, m_rc;
    bit lq[$];
    bit rq[$];

    task automatic model_reset();
        m_ph = M_ASSERT; m_el = 0; m_rc = 0;
        lq = '{1'b0, 1'b0, 1'b0};
        rq = '{1'b0, 1'b0, 1'b0};
    endtask

    task automatic model_step();
        bit ls, rs, tmo;
        int nx;
        if (rst) begin
            model_reset();
            return;
        end
        ls = lq.pop_front();
        rs = rq.pop_front();
        lq.push_back(lk);
        rq.push_back(rd);
        nx  = m_ph;
        tmo = 1'b0;
        if (req) begin
            m_ph = M_ASSERT; m_el = 0; m_rc = 0;
            return;
        end
        case (m_ph)
            M_ASSERT: if (m_el + 1 == P) nx = M_WL;
            M_WL:     if (ls) nx = M_SET; else tmo = (m_el + 1 == TMO);
            M_SET:    if (!ls) nx = M_ASSERT; else if (m_el + 1 == S) nx = M_WR;
            M_WR:     if (!ls) nx = M_ASSERT; else if (rs) nx = M_RUN;
                      else tmo = (m_el + 1 == TMO);
            M_RUN:    if (!(ls && rs)) nx = M_ASSERT;
            default:  nx = M_FAIL;
        endcase
        if (tmo) begin
            m_rc = (m_rc < 15) ? m_rc + 1 : 15;
            nx   = (m_rc >= MR) ? M_FAIL : M_ASSERT;
        end
        m_el = (nx != m_ph) ? 0 : m_el + 1;
        m_ph = nx;
    endtask

    function automatic logic [7:0] model_exp();
        return pk(m_ph == M_ASSERT || m_ph == M_FAIL,
                  m_ph == M_ASSERT || m_ph == M_WL || m_ph == M_SET || m_ph == M_FAIL,
                  m_ph == M_RUN, m_ph == M_FAIL, m_rc);
    endfunction

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // nominal bring-up then a one-cycle lock drop from RUN
        vt[0]  = mk(1, 0, 1, 0, 2, pk(1, 1, 0, 0, 0));
        vt[1]  = mk(0, 0, 1, 0, 3, pk(1, 1, 0, 0, 0));
        vt[2]  = mk(0, 0, 1, 0, 1, pk(0, 1, 0, 0, 0));
        vt[3]  = mk(0, 0, 1, 0, 1, pk(0, 1, 0, 0, 0));
        vt[4]  = mk(0, 0, 1, 0, 7, pk(0, 1, 0, 0, 0));
        vt[5]  = mk(0, 0, 1, 0, 1, pk(0, 0, 0, 0, 0));
        vt[6]  = mk(0, 0, 1, 0, 9, pk(0, 0, 0, 0, 0));
        vt[7]  = mk(0, 0, 1, 1, 3, pk(0, 0, 0, 0, 0));
        vt[8]  = mk(0, 0, 1, 1, 1, pk(0, 0, 1, 0, 0));
        vt[9]  = mk(0, 0, 0, 1, 1, pk(0, 0, 1, 0, 0));
        vt[10] = mk(0, 0, 1, 1, 2, pk(0, 0, 1, 0, 0));
        vt[11] = mk(0, 0, 1, 1, 1, pk(1, 1, 0, 0, 0));
        vt[12] = mk(0, 0, 1, 1, 4, pk(0, 1, 0, 0, 0));
        vt[13] = mk(0, 0, 1, 1, 9, pk(0, 0, 0, 0, 0));
        vt[14] = mk(0, 0, 1, 1, 1, pk(0, 0, 1, 0, 0));

        for (int i = 0; i < 15; i++) begin
            rst = vt[i].rst; req = vt[i].req;
            lk  = vt[i].lk;  rd  = vt[i].rd;
            run(vt[i].n);
            check($sformatf("vec%0d", i), vt[i].exp);
        end
        req = 1'b0;

        // lock never arrives: three timeouts end in FAIL
        lk = 1'b0; rd = 1'b0; rst = 1'b1; run(2); rst = 1'b0;
        run(4);  check("tmo_wl0",     pk(0, 1, 0, 0, 0));
        run(63); check("tmo_wl0_end", pk(0, 1, 0, 0, 0));
        run(1);  check("tmo_1",       pk(1, 1, 0, 0, 1));
        run(3);  check("tmo_pulse",   pk(1, 1, 0, 0, 1));
        run(1);  check("tmo_wl1",     pk(0, 1, 0, 0, 1));
        run(64); check("tmo_2",       pk(1, 1, 0, 0, 2));
        run(4);  check("tmo_wl2",     pk(0, 1, 0, 0, 2));
        run(63); check("tmo_wl2_end", pk(0, 1, 0, 0, 2));
        run(1);  check("tmo_fail",    pk(1, 1, 0, 1, 3));
        run(20); check("fail_hold",   pk(1, 1, 0, 1, 3));

        // req_reset out of FAIL, then again mid-pulse
        req = 1'b1; run(1); req = 1'b0;
        check("req_in_fail", pk(1, 1, 0, 0, 0));
        run(2);
        req = 1'b1; run(1); req = 1'b0;
        check("req_mid_pulse", pk(1, 1, 0, 0, 0));
        run(3); check("req_pulse_ext", pk(1, 1, 0, 0, 0));
        run(1); check("req_pulse_end", pk(0, 1, 0, 0, 0));

        // ready qualifies on the final timeout cycle of WAIT_READY
        lk = 1'b1; rd = 1'b0; rst = 1'b1; run(2); rst = 1'b0;
        run(73); check("tie_pre", pk(0, 0, 0, 0, 0));
        rd = 1'b1;
        run(3); check("tie_wait", pk(0, 0, 0, 0, 0));
        run(1); check("tie_run",  pk(0, 0, 1, 0, 0));

        // asynchronous reset in SETTLE, between clock edges
        rd = 1'b0; rst = 1'b1; run(2); rst = 1'b0;
        run(6); check("settle_pre", pk(0, 1, 0, 0, 0));
        #2 rst = 1'b1;
        #1 check("async_rst", pk(1, 1, 0, 0, 0));
        run(2); rst = 1'b0;
        run(3); check("rst_pulse",     pk(1, 1, 0, 0, 0));
        run(1); check("rst_pulse_end", pk(0, 1, 0, 0, 0));

        // randomized run against the model
        lk = 1'b1; rd = 1'b0; req = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            rst = (i == 0) || ($urandom_range(0, 1499) == 0);
            if ($urandom_range(0, 49) == 0) lk = ~lk;
            if ($urandom_range(0, 24) == 0) rd = ~rd;
            req = ($urandom_range(0, 299) == 0);
            @(posedge clk);
            model_step();
            @(negedge clk);
            check("rand", model_exp());
        end
        rst = 1'b0; req = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
